// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage core: load-use stalls,
// branch squash, multi-cycle EX hold and saturating stall/flush counters.
module hazard_stall_controller #(
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_ex_memread,
  input  logic [2:0]       id_ex_rd,
  input  logic             id_ex_mc_op,
  input  logic             ex_branch_taken,
  input  logic             perf_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

  // The entry cycle in RUN and the final mc_cnt==0 cycle both stall, hence -3.
  localparam logic [7:0]       MC_LOAD = 8'(MC_CYCLES - 3);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r, state_nxt_s;
  logic [7:0]       mc_cnt_r, mc_cnt_nxt_s;
  logic             busy_r;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic             lu_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign lu_s = id_ex_memread && (id_ex_rd != 3'd0) &&
                ((id_ex_rd == id_rs) || (id_uses_rt && (id_ex_rd == id_rt)));

  // Next-state and combinational pipeline controls.
  always_comb begin
    state_nxt_s  = state_r;
    mc_cnt_nxt_s = mc_cnt_r;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    if (rst) begin
      state_nxt_s  = RUN;
      mc_cnt_nxt_s = 8'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (id_ex_mc_op) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_hold      = 1'b1;
            mc_cnt_nxt_s = MC_LOAD;
            state_nxt_s  = MC_BUSY;
          end else if (lu_s) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end
        MC_BUSY: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ex_hold     = 1'b1;
          if (mc_cnt_r == 8'd0) begin
            state_nxt_s = RUN;
          end else begin
            mc_cnt_nxt_s = mc_cnt_r - 8'd1;
          end
        end
        default: begin
          state_nxt_s  = RUN;
          mc_cnt_nxt_s = 8'd0;
        end
      endcase
    end
  end

  // FSM state, multi-cycle down-counter and registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= RUN;
      mc_cnt_r <= 8'd0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      mc_cnt_r <= mc_cnt_nxt_s;
      busy_r   <= (state_nxt_s == MC_BUSY);
    end
  end

  // Saturating performance counters; perf_clr wins over an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (perf_clr) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_r <= pc_write    ? stall_cnt_r : sat_inc(stall_cnt_r);
      flush_cnt_r <= if_id_flush ? sat_inc(flush_cnt_r) : flush_cnt_r;
    end
  end

  assign busy      = busy_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

  hazard_stall_checker u_chk (
    .clk            (clk),
    .rst            (rst),
    .in_run         (state_r == RUN),
    .id_ex_mc_op    (id_ex_mc_op),
    .ex_branch_taken(ex_branch_taken)
  );

endmodule

// Simulation-only checks on ISA-level input constraints.
module hazard_stall_checker (
  input logic clk,
  input logic rst,
  input logic in_run,
  input logic id_ex_mc_op,
  input logic ex_branch_taken
);

  a_mc_branch_excl: assert property (@(posedge clk) disable iff (rst)
    in_run |-> !(id_ex_mc_op && ex_branch_taken))
    else $error("id_ex_mc_op and ex_branch_taken both high in RUN");

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: stimulus pushes expected outputs into a queue, a monitor
// pops and compares each cycle on the falling edge.
module tb_hazard_stall_controller;

  logic       clk, rst;
  logic [2:0] id_rs, id_rt, id_ex_rd;
  logic       id_uses_rt, id_ex_memread, id_ex_mc_op, ex_branch_taken, perf_clr;

  logic        a_pcw, a_ifw, a_fl, a_bub, a_hold, a_busy;
  logic [15:0] a_stall, a_flush;
  logic        b_pcw, b_ifw, b_fl, b_bub, b_hold, b_busy;
  logic [3:0]  b_stall, b_flush;

  hazard_stall_controller #(.MC_CYCLES(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd), .id_ex_mc_op(id_ex_mc_op),
    .ex_branch_taken(ex_branch_taken), .perf_clr(perf_clr),
    .pc_write(a_pcw), .if_id_write(a_ifw), .if_id_flush(a_fl), .id_ex_bubble(a_bub),
    .ex_hold(a_hold), .busy(a_busy), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  hazard_stall_controller #(.MC_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd), .id_ex_mc_op(id_ex_mc_op),
    .ex_branch_taken(ex_branch_taken), .perf_clr(perf_clr),
    .pc_write(b_pcw), .if_id_write(b_ifw), .if_id_flush(b_fl), .id_ex_bubble(b_bub),
    .ex_hold(b_hold), .busy(b_busy), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  // eo = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, busy}
  typedef struct {
    string      nm;
    int         which;
    logic [5:0] eo;
    int         es;
    int         ef;
  } exp_t;

  exp_t exp_q[$];
  bit   stim_done = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input string nm, input int w, input logic [5:0] eo,
                      input int es, input int ef);
    exp_t e;
    e.nm = nm; e.which = w; e.eo = eo; e.es = es; e.ef = ef;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input string nm, input int w, input logic [2:0] rs,
                     input logic [2:0] rt, input logic urt, input logic mr,
                     input logic [2:0] rd, input logic mc, input logic br,
                     input logic clr, input logic [5:0] eo, input int es, input int ef);
    @(posedge clk); #1;
    rst = 1'b0;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; id_ex_memread = mr;
    id_ex_rd = rd; id_ex_mc_op = mc; ex_branch_taken = br; perf_clr = clr;
    push(nm, w, eo, es, ef);
  endtask

  task automatic idle(input string nm, input int w, input logic [5:0] eo,
                      input int es, input int ef);
    cyc(nm, w, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, eo, es, ef);
  endtask

  task automatic lu(input string nm, input int w, input logic clr,
                    input logic [5:0] eo, input int es, input int ef);
    cyc(nm, w, 3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, clr, eo, es, ef);
  endtask

  // Asserts rst mid-cycle with a load-use on the inputs: outputs must be forced.
  task automatic do_reset(input string nm, input int w);
    @(posedge clk); #1;
    rst = 1'b1;
    id_rs = 3'd3; id_rt = 3'd0; id_uses_rt = 1'b0; id_ex_memread = 1'b1;
    id_ex_rd = 3'd3; id_ex_mc_op = 1'b0; ex_branch_taken = 1'b0; perf_clr = 1'b0;
    push(nm, w, 6'b110000, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    id_rs = 3'd0; id_rt = 3'd0; id_uses_rt = 1'b0; id_ex_memread = 1'b0;
    id_ex_rd = 3'd0; id_ex_mc_op = 1'b0; ex_branch_taken = 1'b0; perf_clr = 1'b0;

    do_reset("reset_a", 0);
    lu("lu_rs", 0, 1'b0, 6'b000100, 0, 0);
    idle("lu_after", 0, 6'b110000, 1, 0);
    cyc("rd0_rs0", 0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 6'b110000, 1, 0);
    cyc("rt_unused", 0, 3'd1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 6'b110000, 1, 0);
    cyc("no_memread", 0, 3'd4, 3'd0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 6'b110000, 1, 0);
    cyc("lu_rt", 0, 3'd1, 3'd5, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 6'b000100, 1, 0);
    idle("lu_rt_after", 0, 6'b110000, 2, 0);

    do_reset("reset_mc4", 0);
    cyc("mc4_t0", 0, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 6'b000010, 0, 0);
    cyc("mc4_t1_ign", 0, 3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 6'b000011, 1, 0);
    idle("mc4_t2", 0, 6'b000011, 2, 0);
    cyc("mc4_b2b_t0", 0, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 6'b000010, 3, 0);
    idle("mc4_b2b_t1", 0, 6'b000011, 4, 0);
    idle("mc4_b2b_t2", 0, 6'b000011, 5, 0);
    idle("mc4_b2b_t3", 0, 6'b110000, 6, 0);

    do_reset("reset_mc3", 1);
    cyc("mc3_t0", 1, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 6'b000010, 0, 0);
    idle("mc3_t1", 1, 6'b000011, 1, 0);
    idle("mc3_t2", 1, 6'b110000, 2, 0);
    idle("mc3_t3", 1, 6'b110000, 2, 0);

    do_reset("reset_br", 0);
    cyc("br_over_lu", 0, 3'd3, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 6'b111100, 0, 0);
    idle("br_after", 0, 6'b110000, 0, 1);

    do_reset("reset_pre_mid", 0);
    cyc("mid_t0", 0, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 6'b000010, 0, 0);
    do_reset("rst_mid_op", 0);
    idle("mid_rel0", 0, 6'b110000, 0, 0);
    idle("mid_rel1", 0, 6'b110000, 0, 0);

    do_reset("reset_sat", 1);
    for (int i = 0; i < 20; i++) lu("sat", 1, 1'b0, 6'b000100, (i < 15) ? i : 15, 0);
    lu("clr_w_stall", 1, 1'b1, 6'b000100, 15, 0);
    idle("clr_after", 1, 6'b110000, 0, 0);
    lu("recount", 1, 1'b0, 6'b000100, 0, 0);
    idle("recount_after", 1, 6'b110000, 1, 0);

    @(posedge clk); #1;
    stim_done = 1'b1;
  end

  // Monitor: sole owner of the comparison and failure counts.
  initial begin : monitor
    exp_t       e;
    logic [5:0] go;
    int         gs, gf, cycles;
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.which == 0) begin
          go = {a_pcw, a_ifw, a_fl, a_bub, a_hold, a_busy};
          gs = int'(a_stall); gf = int'(a_flush);
        end else begin
          go = {b_pcw, b_ifw, b_fl, b_bub, b_hold, b_busy};
          gs = int'(b_stall); gf = int'(b_flush);
        end
        n_cmp++;
        if (go !== e.eo || gs != e.es || gf != e.ef) begin
          n_fail++;
          $display("FAIL %s dut%0d: outs got=%b exp=%b stall got=%0d exp=%0d flush got=%0d exp=%0d",
                   e.nm, e.which, go, e.eo, gs, e.es, gf, e.ef);
        end
      end else if (stim_done || cycles > 3000) begin
        if (!stim_done) begin
          n_fail++;
          $display("FAIL timeout: stimulus got=unfinished exp=finished within 3000 cycles");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    end
  end

endmodule
